// File: rtl/onehot_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onehot_arb_pkg
// Purpose  : Shared sizes and state encoding for the 8-line round-robin
//            one-hot arbiter and its pick network.
// Revision : 1.0 - initial release
// ============================================================================
package onehot_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    // Two-state handshake controller: waiting for work, or holding a grant.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage : onehot_arb_pkg
`default_nettype wire

// File: rtl/rr_pick_8.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_8
// Purpose  : Combinational round-robin pick. Rotates the pending vector so
//            that ptr lands on bit 0, takes the lowest set bit, then rotates
//            the result back. Outputs are meaningless when pending_i is zero.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick_8
    import onehot_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_onehot_o,
    output logic [IDX_W-1:0]   pick_idx_o
);

    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_rot_first;
    logic [IDX_W-1:0]   w_rot_idx;

    // Rotate right by ptr: w_rot[k] is the source k positions after ptr.
    // Index arithmetic is IDX_W wide, so the wrap modulo 8 is free.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rot[i] = pending_i[IDX_W'(i) + ptr_i];
        end
    end

    // Isolate the lowest set bit of the rotated vector (fixed priority).
    assign w_rot_first = w_rot & (~w_rot + NUM_REQ'(1));

    // Rotate the isolated bit back into source numbering.
    always_comb begin
        pick_onehot_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_onehot_o[i] = w_rot_first[IDX_W'(i) - ptr_i];
        end
    end

    // Position of the winner in rotated space; scanning downward leaves the
    // lowest set position as the final value.
    always_comb begin
        w_rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_rot_idx = i[IDX_W-1:0];
            end
        end
    end

    assign pick_idx_o = w_rot_idx + ptr_i;

endmodule : rr_pick_8
`default_nettype wire

// File: rtl/rr_onehot_arb_8.sv
`default_nettype none
// ============================================================================
// Module   : rr_onehot_arb_8
// Purpose  : Eight-line round-robin arbiter producing a strictly one-hot
//            grant with a valid/ready handshake for the downstream encoder.
//            Requests are captured into a pending register; one pending line
//            is granted at a time and held until accepted.
// Options  : RR_ARB_REQ_EDGE_EN - when defined, only a 0->1 transition on a
//            request line creates a pending request; otherwise requests are
//            level-captured every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rr_onehot_arb_8
    import onehot_arb_pkg::*;
#(
    parameter int RESET_PTR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    input  logic               grant_ready,
    output logic [NUM_REQ-1:0] pending,
    output logic               busy
);

    localparam logic [IDX_W-1:0] c_reset_ptr = IDX_W'(RESET_PTR);

    arb_state_t          state_q,       state_d;
    logic [NUM_REQ-1:0]  pending_q,     pending_d;
    logic [NUM_REQ-1:0]  grant_q,       grant_d;
    logic                grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]    ptr_q,         ptr_d;
    logic [IDX_W-1:0]    grant_idx_q,   grant_idx_d;

    logic [NUM_REQ-1:0]  w_cap;
    logic [NUM_REQ-1:0]  w_clr;
    logic                w_accept;
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [IDX_W-1:0]    w_pick_idx;

`ifdef RR_ARB_REQ_EDGE_EN
    logic [NUM_REQ-1:0]  req_q;

    // Request history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req;
        end
    end

    assign w_cap = req & ~req_q;
`else
    assign w_cap = req;
`endif

    // Only the accepted grant bit is cleared; a capture on the same bit wins.
    assign w_accept  = grant_valid_q & grant_ready;
    assign w_clr     = grant_q & {NUM_REQ{w_accept}};
    assign pending_d = (pending_q & ~w_clr) | w_cap;

    rr_pick_8 u_pick (
        .pending_i     (pending_q),
        .ptr_i         (ptr_q),
        .pick_onehot_o (w_pick_onehot),
        .pick_idx_o    (w_pick_idx)
    );

    // Next-state: arbitrate only from IDLE, hold the grant until accepted.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        ptr_d         = ptr_q;
        grant_idx_d   = grant_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    grant_d       = w_pick_onehot;
                    grant_valid_d = 1'b1;
                    grant_idx_d   = w_pick_idx;
                    state_d       = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_accept) begin
                    ptr_d         = grant_idx_q + IDX_W'(1);
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State, pending and grant registers; reset drops any outstanding grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= c_reset_ptr;
            grant_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign pending     = pending_q;
    assign busy        = (|pending_q) | grant_valid_q;

endmodule : rr_onehot_arb_8
`default_nettype wire

// File: doc/rr_onehot_arb_8.md
Name: rr_onehot_arb_8

Overview:
- Eight-line round-robin request arbiter; sits directly upstream of the 8-to-3 encoder stage.
- Captures asynchronous-in-time request lines into a pending register.
- Selects one pending line fairly and presents it as a strictly one-hot 8-bit grant with a valid/ready handshake.
- The downstream encoder therefore never sees multiple-hot or all-zero codes while valid is high.

Parameters:
- RESET_PTR, 0, round-robin start index after reset (0..7); index RESET_PTR has highest priority for the first arbitration.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req  input  8  request lines; bit i = request from source i.
- grant  output  8  one-hot selected source; all zero when grant_valid=0.
- grant_valid  output  1  grant holds a valid one-hot code.
- grant_ready  input  1  downstream accepts grant this cycle.
- pending  output  8  registered pending-request vector (status).
- busy  output  1  high when pending≠0 or grant_valid=1.

Behaviour:
- Reset (rst_n=0 at rising edge):
  - pending=0, grant=0, grant_valid=0, ptr=RESET_PTR, state=IDLE.
  - Edge-detect history register cleared to 0.
  - Reset mid-handshake drops the outstanding grant without acceptance.
- Capture: each cycle, pending[i] <= (pending[i] & ~clr[i]) | cap[i].
  - cap depends on the optional feature.
  - clr[i] is high only for the accepted bit, i.e. when grant_valid & grant_ready & grant[i].
  - Simultaneous clr and cap on the same bit: cap wins; the bit stays pending.
- State machine (2 states):
  - IDLE: grant_valid=0. If pending≠0, pick the first set bit scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8). Register grant=onehot(pick) and grant_valid=1; go to GRANT. If pending=0, stay in IDLE.
  - GRANT: grant and grant_valid are held stable while grant_ready=0. No re-arbitration occurs, even if higher-priority bits arrive.
  - GRANT, on grant_valid & grant_ready: clear that pending bit, set ptr <= (idx+1) mod 8, grant <= 0, grant_valid <= 0, go to IDLE.
- Throughput: one grant per 2 cycles maximum, because IDLE always inserts one bubble cycle.
- Latency: a req bit sampled at edge N sets pending after N. If the arbiter is idle and no other bit is pending, grant_valid rises after edge N+1.
- Invariants:
  - grant has exactly one bit set whenever grant_valid=1.
  - grant is a subset of pending while valid.
  - busy = |pending | grant_valid.
- All-ones requests: served in strict rotation from ptr, each source once per 8 grants.
- grant_ready while grant_valid=0 is ignored.

Optional Feature:
- Macro: RR_ARB_REQ_EDGE_EN.
- Defined: cap[i] = req[i] & ~req_q[i], where req_q is req registered each cycle. Only a 0→1 transition creates a pending request; a held-high line is granted once.
- Undefined: cap[i] = req[i] (level capture). A held-high line re-pends immediately after acceptance and is re-granted on its next round-robin turn. req_q is not implemented.

Decomposition:
- Shared package onehot_arb_pkg:
  - NUM_REQ=8, IDX_W=3.
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
- Sub-module rr_pick_8 (combinational): inputs pending[7:0] and ptr[2:0]; outputs pick_onehot[7:0] and pick_idx[2:0].
  - Implemented as rotate by ptr, fixed-priority find-first, then rotate back.
  - The top level instantiates it once.

Test Plan:
1. Reset and idle: hold rst_n=0 for 2 cycles with req=8'hFF, then release with req=0 → grant=0, grant_valid=0, pending=0, busy=0 throughout.
2. Single request: req=8'b0000_0100 pulse for 1 cycle, grant_ready=1 → grant=8'b0000_0100 two edges later for exactly 1 cycle; afterwards pending=0 and ptr=3.
3. Round-robin fairness: req=8'hFF held, grant_ready=1, RESET_PTR=0, level mode → grant sequence 01,02,04,08,10,20,40,80,01, each spaced 2 cycles.
4. Backpressure: pending=8'b1000_0001, grant_ready=0 for 5 cycles → grant=8'h01 stable with grant_valid=1. Then ready=1 → next grant 8'h80.
5. Simultaneous clear and re-request: in level mode, hold req[3]=1 while its grant is accepted → pending[3] stays 1; with RR_ARB_REQ_EDGE_EN defined → pending[3] clears and is not re-granted until req[3] toggles 0→1.
6. Reset mid-handshake: grant_valid=1, grant=8'h10, assert rst_n=0 for one edge → next cycle grant=0, grant_valid=0, pending=0, ptr=RESET_PTR.
